text_console_ctrl: RTL

- Terminal-style controller that owns the write port of the 80x30 text RAM (one byte per cell, ASCII code) that the text-mode framebuffer reads.
- Consumes a stream of ASCII bytes over a valid/ready handshake and tracks the cursor.
- Handles CR/LF/BS/FF and line wrap, clears the RAM on reset.
- Scrolls by rotating a top-row offset exported to the framebuffer, then blanks the newly exposed line, instead of copying RAM.

---
 rtl/text_console_ctrl_if.sv | 9 +
 rtl/text_console_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/text_console_ctrl_if.sv
// rtl/text_console_ctrl_if.sv - byte stream into the text console controller.
interface text_console_ctrl_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/text_console_ctrl.sv
// rtl/text_console_ctrl.sv - terminal-style writer for the 80x30 text RAM with scroll-by-offset.
module text_console_ctrl #(
  parameter int         COLS = 80,
  parameter int         ROWS = 30,
  parameter logic [7:0] FILL = 8'd0
) (
  input  logic               clk,
  input  logic               rst,
  text_console_ctrl_if.slave in_bus,
  output logic               ram_we,
  output logic [11:0]        ram_addr,
  output logic [7:0]         ram_wdata,
  output logic [4:0]         top_row,
  output logic [6:0]         cur_col,
  output logic [4:0]         cur_row,
  output logic               busy
);

  localparam logic [11:0] CELLS    = 12'(COLS * ROWS);
  localparam logic [11:0] LINE     = 12'(COLS);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, LINECLR} state_t;

  state_t      state;
  logic [11:0] cnt;
  logic [4:0]  bottom;
  logic [4:0]  next_row;
  logic        at_bottom;
  logic        accept;
  logic [7:0]  data;

  function automatic logic [4:0] row_inc(input logic [4:0] r);
    return (r == LAST_ROW) ? 5'd0 : r + 5'd1;
  endfunction

  function automatic logic [11:0] row_base(input logic [4:0] r);
    return 12'(r) * LINE;
  endfunction

  assign bottom          = (top_row == 5'd0) ? LAST_ROW : top_row - 5'd1;
  assign next_row        = row_inc(cur_row);
  assign at_bottom       = (cur_row == bottom);
  assign in_bus.in_ready = (state == IDLE);
  assign busy            = (state != IDLE);
  assign accept          = in_bus.in_valid && (state == IDLE);
  assign data            = in_bus.in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      cnt       <= 12'd0;
      ram_we    <= 1'b0;
      ram_addr  <= 12'd0;
      ram_wdata <= 8'd0;
      top_row   <= 5'd0;
      cur_col   <= 7'd0;
      cur_row   <= 5'd0;
    end else begin
      ram_we <= 1'b0;
      unique case (state)
        CLEAR: begin
          if (cnt < CELLS) begin
            ram_we    <= 1'b1;
            ram_addr  <= cnt;
            ram_wdata <= FILL;
            cnt       <= cnt + 12'd1;
          end else begin
            state <= IDLE;
          end
        end
        LINECLR: begin
          if (cnt < LINE) begin
            ram_we    <= 1'b1;
            ram_addr  <= row_base(cur_row) + cnt;
            ram_wdata <= FILL;
            cnt       <= cnt + 12'd1;
          end else begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (accept) begin
            if (data >= 8'd32 && data <= 8'd126) begin
              ram_we    <= 1'b1;
              ram_addr  <= row_base(cur_row) + 12'(cur_col);
              ram_wdata <= data;
              if (cur_col < LAST_COL) begin
                cur_col <= cur_col + 7'd1;
              end else begin
                cur_col <= 7'd0;
                cur_row <= next_row;
                if (at_bottom) begin
                  top_row <= row_inc(top_row);
                  state   <= LINECLR;
                  cnt     <= 12'd0;
                end
              end
            end else begin
              case (data)
                8'd13: cur_col <= 7'd0;
                8'd10: begin
                  cur_col <= 7'd0;
                  cur_row <= next_row;
                  // LF itself writes nothing, so the first blanking write starts on the accept edge
                  if (at_bottom) begin
                    top_row   <= row_inc(top_row);
                    state     <= LINECLR;
                    ram_we    <= 1'b1;
                    ram_addr  <= row_base(next_row);
                    ram_wdata <= FILL;
                    cnt       <= 12'd1;
                  end
                end
                8'd8: begin
                  if (cur_col != 7'd0) begin
                    cur_col   <= cur_col - 7'd1;
                    ram_we    <= 1'b1;
                    ram_addr  <= row_base(cur_row) + 12'(cur_col - 7'd1);
                    ram_wdata <= FILL;
                  end
                end
                8'd12: begin
                  state     <= CLEAR;
                  cur_col   <= 7'd0;
                  cur_row   <= 5'd0;
                  top_row   <= 5'd0;
                  ram_we    <= 1'b1;
                  ram_addr  <= 12'd0;
                  ram_wdata <= FILL;
                  cnt       <= 12'd1;
                end
                default: ;
              endcase
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
